// File: rtl/cache_axi_bridge.sv
// Cache line refill/writeback bridge to an AXI4 master port.
// Moves one whole cache line per request as a single INCR burst of 64-bit beats.
module cache_axi_bridge #(
    parameter int ID_WIDTH   = 4,
    parameter int AXI_ID     = 0,
    parameter int LINE_BEATS = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [31:0]                req_addr,
    input  logic [LINE_BEATS*64-1:0]   req_wdata,

    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [LINE_BEATS*64-1:0]   resp_rdata,
    output logic                       resp_err,

    output logic [ID_WIDTH-1:0]        m_axi_awid,
    output logic [31:0]                m_axi_awaddr,
    output logic [7:0]                 m_axi_awlen,
    output logic [2:0]                 m_axi_awsize,
    output logic [1:0]                 m_axi_awburst,
    output logic                       m_axi_awvalid,
    input  logic                       m_axi_awready,

    output logic [63:0]                m_axi_wdata,
    output logic [7:0]                 m_axi_wstrb,
    output logic                       m_axi_wlast,
    output logic                       m_axi_wvalid,
    input  logic                       m_axi_wready,

    input  logic [ID_WIDTH-1:0]        m_axi_bid,
    input  logic [1:0]                 m_axi_bresp,
    input  logic                       m_axi_bvalid,
    output logic                       m_axi_bready,

    output logic [ID_WIDTH-1:0]        m_axi_arid,
    output logic [31:0]                m_axi_araddr,
    output logic [7:0]                 m_axi_arlen,
    output logic [2:0]                 m_axi_arsize,
    output logic [1:0]                 m_axi_arburst,
    output logic                       m_axi_arvalid,
    input  logic                       m_axi_arready,

    input  logic [ID_WIDTH-1:0]        m_axi_rid,
    input  logic [63:0]                m_axi_rdata,
    input  logic [1:0]                 m_axi_rresp,
    input  logic                       m_axi_rlast,
    input  logic                       m_axi_rvalid,
    output logic                       m_axi_rready
);

    localparam int LW = LINE_BEATS * 64;
    localparam int BW = $clog2(LINE_BEATS);
    localparam logic [BW-1:0]       LAST_BEAT  = BW'(LINE_BEATS - 1);
    localparam logic [ID_WIDTH-1:0] ID         = ID_WIDTH'(AXI_ID);
    localparam logic [31:0]         ALIGN_MASK = ~32'(LINE_BEATS * 8 - 1);
    localparam logic [7:0]          BURST_LEN  = 8'(LINE_BEATS - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_AW   = 3'd3;
    localparam logic [2:0] S_W    = 3'd4;
    localparam logic [2:0] S_B    = 3'd5;
    localparam logic [2:0] S_RESP = 3'd6;

    logic [2:0]    state;
    logic [31:0]   addr_q;
    logic [LW-1:0] wline_q;
    logic [LW-1:0] rline_q;
    logic [BW-1:0] beat_cnt;
    logic          err_q;
    logic [BW+5:0] beat_lsb;
    logic          req_fire;
    logic          last_beat;
    logic          r_bad;
    logic          b_bad;

    assign req_fire  = (state == S_IDLE) && req_valid;
    assign last_beat = (beat_cnt == LAST_BEAT);
    assign beat_lsb  = {beat_cnt, 6'd0};
    assign r_bad     = (m_axi_rresp != 2'b00) || (m_axi_rid != ID) || (m_axi_rlast != last_beat);
    assign b_bad     = (m_axi_bresp != 2'b00) || (m_axi_bid != ID);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            beat_cnt <= '0;
            err_q    <= 1'b0;
            rline_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        beat_cnt <= '0;
                        err_q    <= 1'b0;
                        state    <= req_write ? S_AW : S_AR;
                    end
                end
                S_AR: if (m_axi_arready) state <= S_R;
                // The burst length, not rlast, decides when the refill is done.
                S_R: begin
                    if (m_axi_rvalid) begin
                        rline_q[beat_lsb +: 64] <= m_axi_rdata;
                        beat_cnt                <= beat_cnt + BW'(1);
                        if (r_bad) err_q <= 1'b1;
                        if (last_beat) state <= S_RESP;
                    end
                end
                S_AW: if (m_axi_awready) state <= S_W;
                S_W: begin
                    if (m_axi_wready) begin
                        beat_cnt <= beat_cnt + BW'(1);
                        if (last_beat) state <= S_B;
                    end
                end
                S_B: begin
                    if (m_axi_bvalid) begin
                        if (b_bad) err_q <= 1'b1;
                        state <= S_RESP;
                    end
                end
                S_RESP: if (resp_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Request payload only needs to be valid while its burst is in flight.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            addr_q  <= req_addr & ALIGN_MASK;
            wline_q <= req_wdata;
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign resp_rdata = rline_q;
    assign resp_err   = err_q;

    assign m_axi_arvalid = (state == S_AR);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = BURST_LEN;
    assign m_axi_arsize  = 3'd3;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arid    = ID;
    assign m_axi_rready  = (state == S_R);

    assign m_axi_awvalid = (state == S_AW);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = BURST_LEN;
    assign m_axi_awsize  = 3'd3;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awid    = ID;

    assign m_axi_wvalid  = (state == S_W);
    assign m_axi_wdata   = wline_q[beat_lsb +: 64];
    assign m_axi_wstrb   = 8'hFF;
    assign m_axi_wlast   = last_beat;
    assign m_axi_bready  = (state == S_B);

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge with a behavioural AXI4 slave memory
// that can stall, inject error responses and mis-place rlast.
module tb_cache_axi_bridge;
    localparam int LB = 8;
    localparam int LW = LB * 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          req_valid, req_ready, req_write;
    logic [31:0]   req_addr;
    logic [LW-1:0] req_wdata;
    logic          resp_valid, resp_ready, resp_err;
    logic [LW-1:0] resp_rdata;

    logic [3:0]  m_axi_awid, m_axi_bid, m_axi_arid, m_axi_rid;
    logic [31:0] m_axi_awaddr, m_axi_araddr;
    logic [7:0]  m_axi_awlen, m_axi_arlen, m_axi_wstrb;
    logic [2:0]  m_axi_awsize, m_axi_arsize;
    logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic [63:0] m_axi_wdata, m_axi_rdata;

    cache_axi_bridge #(.ID_WIDTH(4), .AXI_ID(0), .LINE_BEATS(LB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave knobs, captures and counters
    logic [63:0] mem [0:255];
    bit          stall_en = 0;
    int          rresp_err_beat = -1;
    int          rlast_beat = -1;
    bit          bresp_err = 0;
    int          r_beats = 0, w_beats = 0, wlast_bad = 0, wstrb_bad = 0, viol = 0;
    logic [31:0] cap_araddr, cap_awaddr;
    logic [7:0]  cap_arlen, cap_awlen;
    logic [2:0]  cap_arsize;
    logic [1:0]  cap_arburst;
    logic [3:0]  cap_arid;

    // Slave internals and per-cycle snapshot of the channels
    bit          r_act, w_act, b_pend, p_ok;
    int          r_beat, r_wait, b_wait;
    logic [31:0] r_addr, w_addr;
    logic        p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_wlast, p_rv, p_rr, p_bv, p_br;
    logic [31:0] p_araddr, p_awaddr;
    logic [63:0] p_wdata;
    logic [7:0]  p_wstrb, p_arlen, p_awlen;
    logic [2:0]  p_arsize;
    logic [1:0]  p_arburst;
    logic [3:0]  p_arid;

    function automatic int stall();
        return stall_en ? int'($urandom_range(0, 5)) : 0;
    endfunction

    function automatic int midx(input logic [31:0] a, input int beat);
        return (int'(a[10:3]) + beat) & 255;
    endfunction

    initial begin
        m_axi_arready = 0; m_axi_awready = 0; m_axi_wready = 0;
        m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = 0; m_axi_rlast = 0; m_axi_rid = 0;
        m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_bid = 0;
        r_act = 0; w_act = 0; b_pend = 0; p_ok = 0; r_beat = 0; r_wait = 0; b_wait = 0;
        forever begin
            @(negedge clk);
            if (rst_n && p_ok) begin
                if (p_arv && !p_arr && (!m_axi_arvalid || m_axi_araddr != p_araddr)) viol++;
                if (p_awv && !p_awr && (!m_axi_awvalid || m_axi_awaddr != p_awaddr)) viol++;
                if (p_wv && !p_wr && (!m_axi_wvalid || m_axi_wdata != p_wdata || m_axi_wlast != p_wlast)) viol++;
            end
            if (rst_n) begin
                if (m_axi_arvalid && m_axi_awvalid) viol++;
                if (int'(m_axi_rready) + int'(m_axi_wvalid) + int'(m_axi_bready) > 1) viol++;
            end
            p_ok = rst_n;
            p_arv = m_axi_arvalid; p_arr = m_axi_arready; p_araddr = m_axi_araddr;
            p_arlen = m_axi_arlen; p_arsize = m_axi_arsize; p_arburst = m_axi_arburst; p_arid = m_axi_arid;
            p_awv = m_axi_awvalid; p_awr = m_axi_awready; p_awaddr = m_axi_awaddr; p_awlen = m_axi_awlen;
            p_wv = m_axi_wvalid; p_wr = m_axi_wready; p_wdata = m_axi_wdata; p_wlast = m_axi_wlast; p_wstrb = m_axi_wstrb;
            p_rv = m_axi_rvalid; p_rr = m_axi_rready; p_bv = m_axi_bvalid; p_br = m_axi_bready;

            @(posedge clk); #1;
            if (!rst_n) begin
                m_axi_arready = 0; m_axi_awready = 0; m_axi_wready = 0;
                m_axi_rvalid = 0; m_axi_bvalid = 0; r_act = 0; w_act = 0; b_pend = 0;
                continue;
            end
            if (p_arv && p_arr) begin
                cap_araddr = p_araddr; cap_arlen = p_arlen; cap_arsize = p_arsize;
                cap_arburst = p_arburst; cap_arid = p_arid;
                r_act = 1; r_addr = p_araddr; r_beat = 0; r_beats = 0; r_wait = stall();
            end
            if (p_rv && p_rr) begin
                r_beats++; r_beat++; m_axi_rvalid = 0; r_wait = stall();
                if (r_beat > int'(cap_arlen)) r_act = 0;
            end
            if (p_awv && p_awr) begin
                cap_awaddr = p_awaddr; cap_awlen = p_awlen;
                w_act = 1; w_addr = p_awaddr; w_beats = 0;
            end
            if (p_wv && p_wr) begin
                mem[midx(w_addr, w_beats)] = p_wdata;
                if (p_wstrb != 8'hFF) wstrb_bad++;
                if (p_wlast != (w_beats == int'(cap_awlen))) wlast_bad++;
                w_beats++;
                if (w_beats > int'(cap_awlen)) begin w_act = 0; b_pend = 1; b_wait = stall(); end
            end
            if (p_bv && p_br) m_axi_bvalid = 0;

            if (r_act && !m_axi_rvalid) begin
                if (r_wait > 0) r_wait--;
                else begin
                    m_axi_rvalid = 1;
                    m_axi_rdata  = mem[midx(r_addr, r_beat)];
                    m_axi_rresp  = (r_beat == rresp_err_beat) ? 2'd2 : 2'd0;
                    m_axi_rlast  = (rlast_beat >= 0) ? (r_beat == rlast_beat) : (r_beat == int'(cap_arlen));
                end
            end
            if (b_pend && !m_axi_bvalid) begin
                if (b_wait > 0) b_wait--;
                else begin
                    m_axi_bvalid = 1; m_axi_bresp = bresp_err ? 2'd2 : 2'd0; b_pend = 0;
                end
            end
            m_axi_arready = stall_en ? ($urandom_range(0, 3) == 0) : 1'b1;
            m_axi_awready = stall_en ? ($urandom_range(0, 3) == 0) : 1'b1;
            m_axi_wready  = stall_en ? ($urandom_range(0, 3) == 0) : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [LW-1:0] mkline(input logic [63:0] base, input logic [63:0] step);
        logic [LW-1:0] l;
        for (int k = 0; k < LB; k++) l[k*64 +: 64] = base + step * 64'(k);
        return l;
    endfunction

    task automatic send_req(input logic wr, input logic [31:0] addr, input logic [LW-1:0] wd);
        int n;
        @(posedge clk); #1;
        req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wd;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready && n < 1000);
        if (!req_ready) check_eq("req_accept_timeout", 0, 1);
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [LW-1:0] wd,
                           input int hold, output logic [LW-1:0] rd, output logic er);
        int n;
        send_req(wr, addr, wd);
        n = 0;
        while (!resp_valid && n < 2000) begin @(negedge clk); n++; end
        check_eq("resp_valid_seen", resp_valid, 1);
        check_eq("req_ready_in_resp", req_ready, 0);
        rd = resp_rdata; er = resp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("resp_valid_hold", resp_valid, 1);
            check_eq("resp_rdata_hold", resp_rdata, rd);
        end
        @(posedge clk); #1;
        resp_ready = 1;
        @(posedge clk); #1;
        resp_ready = 0;
        check_eq("idle_after_resp", {resp_valid, req_ready}, 2'b01);
    endtask

    logic [LW-1:0] rd, exp_pat, wd1, wd2;
    logic          er;
    int            n;

    initial begin
        rst_n = 0; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; resp_ready = 0;
        for (int i = 0; i < 256; i++) mem[i] = 64'hDEAD_0000_0000_0000 | 64'(i);
        for (int k = 0; k < LB; k++) mem[8 + k] = 64'h1111_1111_1111_1111 * 64'(k);
        exp_pat = mkline(64'h0, 64'h1111_1111_1111_1111);
        wd1 = mkline(64'hA5A5_0000_0000_0100, 64'h0000_0001_0000_0001);
        wd2 = mkline(64'hCAFE_F00D_0000_0000, 64'h0123_4567_89AB_CDEF);

        repeat (3) @(posedge clk); #1;
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_resp", {resp_valid, resp_err}, 2'b00);
        check_eq("rst_resp_rdata", resp_rdata, '0);
        check_eq("rst_axi_valids", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready}, 5'b0);
        rst_n = 1;

        // Refill of an unaligned address
        run_txn(0, 32'h8000_0047, '0, 0, rd, er);
        check_eq("ar_addr", cap_araddr, 32'h8000_0040);
        check_eq("ar_len_size_burst_id", {cap_arlen, cap_arsize, cap_arburst, cap_arid}, {8'd7, 3'd3, 2'd1, 4'd0});
        check_eq("refill_data", rd, exp_pat);
        check_eq("refill_err", er, 0);

        // Writeback then refill of the same line
        run_txn(1, 32'h8000_0100, wd1, 0, rd, er);
        check_eq("wb_err", er, 0);
        check_eq("wb_awaddr_len", {cap_awaddr, cap_awlen}, {32'h8000_0100, 8'd7});
        check_eq("wb_beats", w_beats, 8);
        check_eq("wb_wlast_wstrb_bad", {32'(wlast_bad), 32'(wstrb_bad)}, 64'd0);
        run_txn(0, 32'h8000_0100, '0, 0, rd, er);
        check_eq("wb_refill_data", rd, wd1);
        check_eq("wb_refill_err", er, 0);

        // Random stalls with the requester slow to take the response
        stall_en = 1;
        run_txn(1, 32'h8000_0180, wd2, 10, rd, er);
        check_eq("stall_wb_err", er, 0);
        check_eq("stall_wb_beats", w_beats, 8);
        run_txn(0, 32'h8000_0180, '0, 10, rd, er);
        check_eq("stall_refill_data", rd, wd2);
        check_eq("stall_refill_err", er, 0);
        stall_en = 0;

        // Error responses still complete the whole burst
        rresp_err_beat = 3;
        run_txn(0, 32'h8000_0040, '0, 0, rd, er);
        rresp_err_beat = -1;
        check_eq("rresp_err", er, 1);
        check_eq("rresp_err_beats", r_beats, 8);
        check_eq("rresp_err_data", rd, exp_pat);
        bresp_err = 1;
        run_txn(1, 32'h8000_0200, wd2, 0, rd, er);
        bresp_err = 0;
        check_eq("bresp_err", er, 1);
        check_eq("bresp_err_beats", w_beats, 8);

        // Early rlast
        rlast_beat = 5;
        run_txn(0, 32'h8000_0100, '0, 0, rd, er);
        rlast_beat = -1;
        check_eq("early_rlast_err", er, 1);
        check_eq("early_rlast_beats", r_beats, 8);
        check_eq("early_rlast_data", rd, wd1);

        // Reset in the middle of a write burst
        send_req(1, 32'h8000_0300, wd1);
        n = 0;
        while (!(w_act && w_beats == 4) && n < 200) begin @(negedge clk); n++; end
        check_eq("w_beat4_reached", w_beats, 4);
        #2 rst_n = 0;
        #1;
        check_eq("midrst_req_ready", req_ready, 1);
        check_eq("midrst_resp", {resp_valid, resp_err}, 2'b00);
        check_eq("midrst_resp_rdata", resp_rdata, '0);
        check_eq("midrst_axi_valids", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready}, 5'b0);
        repeat (2) @(posedge clk);
        @(negedge clk); #2 rst_n = 1;
        run_txn(0, 32'h8000_0040, '0, 0, rd, er);
        check_eq("post_rst_refill_data", rd, exp_pat);
        check_eq("post_rst_refill_err", er, 0);

        check_eq("protocol_violations", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_axi_bridge.md
CACHE_AXI_BRIDGE -- requirements
Module: cache_axi_bridge

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, the AXI ID width.
REQ-002 SHALL have parameter AXI_ID, default 0, the constant ID driven on m_axi_arid and m_axi_awid.
REQ-003 SHALL have parameter LINE_BEATS, default 8, the number of 64-bit beats per cache line (power of two, 2..16).
REQ-004 clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req_valid/req_ready  in/out  1/1  line request handshake.
REQ-007 req_write  in  1  1 = writeback, 0 = refill.
REQ-008 req_addr  in  32  byte address; low log2(LINE_BEATS*8) bits are ignored.
REQ-009 req_wdata  in  LINE_BEATS*64  writeback line; beat k = bits [64k+63:64k].
REQ-010 resp_valid/resp_ready  out/in  1/1  completion handshake.
REQ-011 resp_rdata  out  LINE_BEATS*64  refill line, same beat packing as req_wdata.
REQ-012 resp_err  out  1  any error during the transaction.
REQ-013 m_axi_aw*/w*/b*/ar*/r*  AXI4 master ports: awid, awaddr[32], awlen[8], awsize[3], awburst[2], awvalid/awready; wdata[64], wstrb[8], wlast, wvalid/wready; bid, bresp[2], bvalid/bready; arid, araddr[32], arlen[8], arsize[3], arburst[2], arvalid/arready; rid, rdata[64], rresp[2], rlast, rvalid/rready.

Function
REQ-014 SHALL implement FSM states IDLE, AR, R, AW, W, B, RESP, with a single outstanding transaction.
REQ-015 IDLE: req_ready=1; on req_valid&req_ready SHALL capture the aligned address, req_write and req_wdata, clear beat_cnt and err, then go to AW if req_write else AR.
REQ-016 AR: arvalid=1, araddr=aligned address, arlen=LINE_BEATS-1, arsize=3, arburst=INCR(01), arid=AXI_ID; on arready go to R.
REQ-017 R: rready=1; each rvalid beat SHALL be written into slot beat_cnt, and beat_cnt SHALL increment.
REQ-018 R: rresp!=0, rid!=AXI_ID, or rlast not matching (beat_cnt==LINE_BEATS-1) SHALL set sticky err.
REQ-019 R: on accepting beat LINE_BEATS-1, SHALL go to RESP regardless of rlast; beats arriving in RESP/IDLE are not accepted (rready=0).
REQ-020 AW: awvalid=1 with the same address/len/size/burst/id encoding as AR; on awready go to W.
REQ-021 W: wvalid=1, wdata=slot beat_cnt, wstrb=8'hFF, wlast=(beat_cnt==LINE_BEATS-1); on wready increment beat_cnt; after the last beat go to B.
REQ-022 B: bready=1; on bvalid set err if bresp!=0 or bid!=AXI_ID, then go to RESP.
REQ-023 RESP: resp_valid=1, resp_err=err, resp_rdata stable; on resp_ready go to IDLE; req_ready=0 until IDLE is re-entered (no same-cycle re-accept).
REQ-024 All AXI valid signals SHALL remain asserted, with address/data stable, until their handshake completes (no retraction).
REQ-025 beat_cnt SHALL be log2(LINE_BEATS) bits and SHALL wrap to 0 only on leaving R/W.
REQ-026 resp_rdata for a write transaction SHALL hold the previous refill contents (unspecified to the requester).
REQ-027 SHALL issue no awvalid and arvalid in the same cycle, and SHALL assert at most one of rready/wvalid/bready per cycle.

Reset
REQ-028 While reset=0: state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, all m_axi valid/ready outputs=0, beat_cnt=0.
REQ-029 Reset asserted mid-transaction SHALL abandon the transaction immediately; the block does not complete or clean up the AXI burst.

Verification
REQ-030 Refill at req_addr=0x8000_0047 with the RAM preloaded with beat k = 0x1111_1111_1111_1111*k -> araddr=0x8000_0040, arlen=7, arsize=3, arburst=1; resp_rdata beats match; resp_err=0.
REQ-031 Writeback at 0x8000_0100 then refill at the same address -> exactly 8 W beats, wlast only on beat 7, wstrb=FF; the refill returns identical data; resp_err=0 on both.
REQ-032 Random rvalid/wready/arready/awready/bvalid stalls (0-5 cycles) plus resp_ready held low for 10 cycles -> same data, valids never drop before handshake, resp_valid held with stable payload.
REQ-033 Slave returns rresp=2 on beat 3 and bresp=2 on a write -> the transaction still completes all beats; resp_err=1 on each.
REQ-034 Slave asserts rlast on beat 5 -> resp_err=1; FSM waits for 8 beats before RESP.
REQ-035 reset driven low during W beat 4, then released -> all outputs at reset values asynchronously; the next refill request completes correctly.
